delay_pipe_ctrl: RTL and testbench

//  Controller for a stall-able, enable-gated register delay pipeline (banks of delay buffers sharing one en).

---
 rtl/delay_pipe_ctrl_pkg.sv | 18 +
 rtl/delay_pipe_ctrl_flag_shift.sv | 30 +++
 rtl/delay_pipe_ctrl.sv | 88 ++++++++
 tb/tb_delay_pipe_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_pipe_ctrl_pkg.sv
// Shared definitions for the delay pipeline controller: FSM states and counter sizing.
package delay_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam int unsigned DEFAULT_DELAY = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_pipe_ctrl_flag_shift.sv
// Enable-gated shift register carrying the per-slot valid and last flags alongside the datapath.
module delay_pipe_ctrl_flag_shift #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] lst_q;

    // Clear wins over enable so an abort invalidates everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (en) begin
            vld_q <= {vld_q[DEPTH-2:0], din[0]};
            lst_q <= {lst_q[DEPTH-2:0], din[1]};
        end
    end

    always_comb begin
        dout = {lst_q[DEPTH-1], vld_q[DEPTH-1]};
    end

endmodule

// File: rtl/delay_pipe_ctrl.sv
// Job sequencer, shared enable and occupancy tracking for an external fixed-latency delay pipe.
module delay_pipe_ctrl
    import delay_pipe_ctrl_pkg::*;
#(
    parameter  int unsigned DELAY = DEFAULT_DELAY,
    localparam int unsigned CW    = cnt_width(DELAY)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic          en,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    flags_out;
    logic          active;
    logic          acc;
    logic          pop;
    logic          clr;

    assign clr = rst | abort;

    delay_pipe_ctrl_flag_shift #(
        .DEPTH (DELAY)
    ) u_flag_shift (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .din  ({acc & s_last, acc}),
        .dout (flags_out)
    );

    // Whole pipe advances only when the final slot is empty or being taken; bubbles stay put.
    always_comb begin
        m_valid = flags_out[0];
        m_last  = flags_out[1] & flags_out[0];
        active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        en      = active & (~m_valid | m_ready);
        s_ready = en & (state_q == ST_RUN);
        acc     = s_valid & s_ready;
        pop     = m_valid & m_ready;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        count   = count_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (acc && s_last) state_d = ST_DRAIN;
            ST_DRAIN: if (count_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        count_d = count_q + CW'(acc) - CW'(pop);
        if (abort) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_delay_pipe_ctrl.sv
// Randomised and directed bench for delay_pipe_ctrl against a beat-age reference model.
module tb_delay_pipe_ctrl;

    localparam int unsigned DELAY = 4;
    localparam int unsigned CW    = 3;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst, start, abort, s_valid, s_last, m_ready;
    logic          s_ready, en, m_valid, m_last, busy, done;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0, out_cnt = 0, done_cnt = 0;

    delay_pipe_ctrl #(
        .DELAY (DELAY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .en      (en),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .busy    (busy),
        .done    (done),
        .count   (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each beat in flight carries its age in enabled cycles; it is
    // presented downstream once its age reaches DELAY.
    typedef struct {
        bit last;
        int age;
    } beat_t;

    beat_t mq[$];
    int    mphase = P_IDLE;

    function automatic logic [CW+5:0] model_out();
        bit mv, ml, act, e, sr;
        mv  = (mq.size() > 0) && (mq[0].age == DELAY);
        ml  = mv && mq[0].last;
        act = (mphase == P_RUN) || (mphase == P_DRAIN);
        e   = act && (!mv || m_ready);
        sr  = e && (mphase == P_RUN);
        return {mphase != P_IDLE, mphase == P_DONE, e, sr, mv, ml, CW'(mq.size())};
    endfunction

    initial begin
        logic [CW+5:0] exp_v, obs_v;
        bit            mv, e, sr, acc;
        int            n;
        beat_t         nb;
        forever begin
            @(negedge clk);
            exp_v = model_out();
            obs_v = {busy, done, en, s_ready, m_valid, m_last, count};
            total++;
            if (obs_v !== exp_v) begin
                bad++;
                $display("FAIL model_outputs cyc=%0d {busy,done,en,s_ready,m_valid,m_last,count} got=%b want=%b",
                         cyc, obs_v, exp_v);
            end
            if (s_valid && s_ready) acc_cnt++;
            if (m_valid && m_ready) out_cnt++;
            if (done) done_cnt++;
            // Advance the model over the coming edge.
            e  = exp_v[CW+3];
            sr = exp_v[CW+2];
            mv = exp_v[CW+1];
            n  = mq.size();
            if (rst || abort) begin
                mq.delete();
                mphase = P_IDLE;
            end else begin
                acc = s_valid && sr;
                if (e) begin
                    if (mv && m_ready) void'(mq.pop_front());
                    foreach (mq[i]) mq[i].age++;
                    if (acc) begin
                        nb.last = s_last;
                        nb.age  = 1;
                        mq.push_back(nb);
                    end
                end
                case (mphase)
                    P_IDLE:  if (start) mphase = P_RUN;
                    P_RUN:   if (acc && s_last) mphase = P_DRAIN;
                    P_DRAIN: if (n == 0) mphase = P_DONE;
                    default: mphase = P_IDLE;
                endcase
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        start = 0; abort = 0; s_valid = 0; s_last = 0; m_ready = 1; rst = 0;
    endtask

    task automatic pulse_start();
        start = 1;
        next_cycle();
        start = 0;
    endtask

    task automatic test_reset();
        rst = 1; s_valid = 1; start = 1; abort = 0; s_last = 0; m_ready = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if ({busy, done, en, s_ready, m_valid, m_last, count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0",
                     {busy, done, en, s_ready, m_valid, m_last, count});
        end
        next_cycle();
        quiet_inputs();
        next_cycle();
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || count !== '0) begin
            bad++;
            $display("FAIL reset_idle busy=%b count=%0d want busy=0 count=0", busy, count);
        end
        next_cycle();
    endtask

    task automatic test_streaming();
        int  first_acc = -1, first_mv = -1, nout = 0, last_idx = -1, done_k = -1, zero_k = -1;
        bit  gap = 0, prev_mv = 0, en_drop = 0;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            s_valid = (k < 6);
            s_last  = (k == 5);
            m_ready = 1;
            @(negedge clk);
            if (s_valid && s_ready && first_acc < 0) first_acc = k;
            if (m_valid) begin
                if (first_mv < 0) first_mv = k;
                else if (!prev_mv) gap = 1;
                nout++;
                if (m_last) last_idx = nout;
            end
            prev_mv = m_valid;
            if (busy && !done && !en) en_drop = 1;
            if (count == 0 && first_mv >= 0 && zero_k < 0) zero_k = k;
            if (done && done_k < 0) done_k = k;
            next_cycle();
            if (done_k >= 0) break;
        end
        quiet_inputs();
        total++;
        if (first_mv - first_acc != DELAY) begin
            bad++;
            $display("FAIL stream_latency got=%0d want=%0d", first_mv - first_acc, DELAY);
        end
        total++;
        if (nout != 6 || gap || last_idx != 6) begin
            bad++;
            $display("FAIL stream_beats got n=%0d gap=%0d last_at=%0d want n=6 gap=0 last_at=6",
                     nout, gap, last_idx);
        end
        total++;
        if (done_k < 0 || done_k != zero_k + 1 || en_drop) begin
            bad++;
            $display("FAIL stream_done got done_k=%0d zero_k=%0d en_drop=%0d want done_k=zero_k+1 en_drop=0",
                     done_k, zero_k, en_drop);
        end
    endtask

    task automatic test_backpressure();
        int nout = 0, last_pos = -1, done_k = -1, acc0;
        pulse_start();
        acc0 = acc_cnt;
        for (int k = 0; k < 30; k++) begin
            s_valid = (k < 3) || (k >= 4 && k <= 8);
            s_last  = (k >= 4 && k <= 8);
            m_ready = !(k >= 4 && k <= 7);
            @(negedge clk);
            if (k == 4) begin
                total++;
                if (m_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_first_valid got=%b want=1", m_valid);
                end
            end
            if (k >= 4 && k <= 7) begin
                total++;
                if ({en, s_ready, count} !== {1'b0, 1'b0, CW'(3)}) begin
                    bad++;
                    $display("FAIL bp_stall k=%0d got en=%b s_ready=%b count=%0d want 0 0 3",
                             k, en, s_ready, count);
                end
            end
            if (m_valid && m_ready) begin
                nout++;
                if (m_last) last_pos = nout;
            end
            if (done && done_k < 0) done_k = k;
            next_cycle();
            if (done_k >= 0) break;
        end
        quiet_inputs();
        total++;
        if (nout != 4 || last_pos != 4 || acc_cnt - acc0 != 4 || done_k != 14) begin
            bad++;
            $display("FAIL bp_resume got out=%0d last_at=%0d acc=%0d done_k=%0d want 4 4 4 14",
                     nout, last_pos, acc_cnt - acc0, done_k);
        end
    endtask

    task automatic test_bubbles();
        bit hist[8];
        int maxc = 0, done_k = -1;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            s_valid = (k == 0) || (k == 2);
            s_last  = (k == 2);
            m_ready = 1;
            @(negedge clk);
            if (k < 8) hist[k] = s_valid && s_ready;
            if (k >= 4 && k < 8) begin
                total++;
                if (m_valid !== hist[k-4]) begin
                    bad++;
                    $display("FAIL bubble_pattern k=%0d got=%b want=%b", k, m_valid, hist[k-4]);
                end
            end
            if (int'(count) > maxc) maxc = int'(count);
            if (done && done_k < 0) done_k = k;
            next_cycle();
            if (done_k >= 0) break;
        end
        quiet_inputs();
        total++;
        if (maxc != 2 || done_k != 8) begin
            bad++;
            $display("FAIL bubble_summary got max_count=%0d done_k=%0d want 2 8", maxc, done_k);
        end
    endtask

    task automatic test_abort();
        bit saw_done = 0;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            s_valid = (k < 3);
            s_last  = (k == 2);
            abort   = (k == 4);
            m_ready = 1;
            @(negedge clk);
            if (k == 5) begin
                total++;
                if ({busy, m_valid, count} !== '0) begin
                    bad++;
                    $display("FAIL abort_clear got busy=%b m_valid=%b count=%0d want 0 0 0",
                             busy, m_valid, count);
                end
            end
            if (k >= 4 && done) saw_done = 1;
            next_cycle();
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL abort_no_done got done pulse want none");
        end
        start = 1;
        abort = 1;
        next_cycle();
        quiet_inputs();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_start_idle got busy=%b want 0", busy);
        end
        next_cycle();
    endtask

    task automatic test_single_beat();
        int done_k = -1;
        pulse_start();
        for (int k = 0; k < 10; k++) begin
            s_valid = (k == 0);
            s_last  = (k == 0);
            start   = (k >= 1 && k <= 5);
            m_ready = 1;
            @(negedge clk);
            if (k == 1) begin
                total++;
                if ({busy, s_ready} !== 2'b10) begin
                    bad++;
                    $display("FAIL single_drain got busy=%b s_ready=%b want 1 0", busy, s_ready);
                end
            end
            if (k == 4) begin
                total++;
                if ({m_valid, m_last} !== 2'b11) begin
                    bad++;
                    $display("FAIL single_out got m_valid=%b m_last=%b want 1 1", m_valid, m_last);
                end
            end
            if (k == 8) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL single_no_restart got busy=%b want 0", busy);
                end
            end
            if (done && done_k < 0) done_k = k;
            next_cycle();
        end
        quiet_inputs();
        total++;
        if (done_k != 6) begin
            bad++;
            $display("FAIL single_done got done_k=%0d want 6", done_k);
        end
    endtask

    task automatic test_back_to_back();
        for (int job = 0; job < 8; job++) begin
            int acc0, out0, done0;
            bit aborted = 0, finished = 0, allow_abort;
            allow_abort = (job % 3 == 2);
            pulse_start();
            acc0  = acc_cnt;
            out0  = out_cnt;
            done0 = done_cnt;
            for (int n = 0; n < 400; n++) begin
                s_valid = ($urandom % 2) == 1;
                s_last  = ($urandom % 5) == 0;
                m_ready = ($urandom % 4) != 0;
                abort   = allow_abort && n > 3 && ($urandom % 30) == 0;
                @(negedge clk);
                if (abort) aborted = 1;
                if (!busy) finished = 1;
                next_cycle();
                if (finished) break;
            end
            quiet_inputs();
            total++;
            if (!finished) begin
                bad++;
                $display("FAIL b2b_timeout job=%0d got busy after 400 cycles want idle", job);
            end else if (!aborted) begin
                if (out_cnt - out0 != acc_cnt - acc0 || done_cnt - done0 != 1) begin
                    bad++;
                    $display("FAIL b2b_conserve job=%0d got out=%0d done=%0d want out=%0d done=1",
                             job, out_cnt - out0, done_cnt - done0, acc_cnt - acc0);
                end
            end
        end
    endtask

    initial begin
        rst = 1; start = 1; abort = 0; s_valid = 1; s_last = 0; m_ready = 1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_abort();
        test_single_beat();
        test_back_to_back();
        repeat (3) next_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
